// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/execute controller driving the program ROM, ALU handshake and datapath strobes
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int ALU_TIMEOUT = 16,
  parameter int MAX_STEPS   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  output logic [1:0]        prog,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        instruction,
  output logic [3:0]        alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  output logic [1:0]        reg_a,
  output logic [1:0]        reg_b,
  output logic              lda_en,
  output logic              ldb_en,
  output logic              push_en,
  output logic              out_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        step_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ALU_WAIT,
    S_DONE,
    S_HALT_ERR
  } state_e;

  localparam int                WCNT_W     = $clog2(ALU_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(ALU_TIMEOUT - 1);
  localparam logic [8:0]        STEP_LIMIT = 9'(MAX_STEPS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [1:0]          prog_q, prog_d;
  logic [7:0]          ir_q, ir_d;
  logic [7:0]          step_q, step_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic                error_q, error_d;
  logic                done_q, done_d;
  logic                alu_start_q, alu_start_d;
  logic                lda_q, lda_d;
  logic                ldb_q, ldb_d;
  logic                push_q, push_d;
  logic                out_q, out_d;
  logic                step_at_max;
  logic                can_advance;

  function automatic logic is_alu_op(input logic [3:0] op);
    return !op[3] || (op[3:1] == 3'b110);
  endfunction

  assign step_at_max = ({1'b0, step_q} >= STEP_LIMIT);
  assign can_advance = !(&address_q) && !step_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      address_q   <= '0;
      prog_q      <= '0;
      ir_q        <= '0;
      step_q      <= '0;
      alu_op_q    <= '0;
      wait_q      <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      alu_start_q <= 1'b0;
      lda_q       <= 1'b0;
      ldb_q       <= 1'b0;
      push_q      <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      prog_q      <= prog_d;
      ir_q        <= ir_d;
      step_q      <= step_d;
      alu_op_q    <= alu_op_d;
      wait_q      <= wait_d;
      error_q     <= error_d;
      done_q      <= done_d;
      alu_start_q <= alu_start_d;
      lda_q       <= lda_d;
      ldb_q       <= ldb_d;
      push_q      <= push_d;
      out_q       <= out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    prog_d      = prog_q;
    ir_d        = ir_q;
    step_d      = step_q;
    alu_op_d    = alu_op_q;
    wait_d      = wait_q;
    error_d     = error_q;
    done_d      = 1'b0;
    alu_start_d = 1'b0;
    lda_d       = 1'b0;
    ldb_d       = 1'b0;
    push_d      = 1'b0;
    out_d       = 1'b0;

    case (state_q)
      S_IDLE, S_HALT_ERR: begin
        if (start) begin
          prog_d    = prog_sel;
          address_d = '0;
          step_d    = '0;
          error_d   = 1'b0;
          state_d   = S_FETCH;
        end
      end
      // Strobes are decoded from the ROM word here so they are registered and land in EXEC.
      S_FETCH: begin
        ir_d    = instruction;
        wait_d  = '0;
        state_d = S_EXEC;
        if (is_alu_op(instruction[7:4])) begin
          alu_start_d = 1'b1;
          alu_op_d    = instruction[7:4];
        end
        case (instruction[7:4])
          4'b1000: push_d = 1'b1;
          4'b1001: lda_d  = 1'b1;
          4'b1010: ldb_d  = 1'b1;
          4'b1011: out_d  = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        if (is_alu_op(ir_q[7:4])) begin
          state_d = S_ALU_WAIT;
        end else if (ir_q[7:4] == 4'b1011) begin
          if (step_at_max) begin
            error_d = 1'b1;
            state_d = S_HALT_ERR;
          end else begin
            step_d  = step_q + 8'd1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (ir_q[7:6] == 2'b10) begin
          if (can_advance) begin
            address_d = address_q + 1'b1;
            step_d    = step_q + 8'd1;
            state_d   = S_FETCH;
          end else begin
            error_d = 1'b1;
            state_d = S_HALT_ERR;
          end
        end else begin
          error_d = 1'b1;
          state_d = S_HALT_ERR;
        end
      end
      S_ALU_WAIT: begin
        if (alu_done) begin
          if (can_advance) begin
            address_d = address_q + 1'b1;
            step_d    = step_q + 8'd1;
            state_d   = S_FETCH;
          end else begin
            error_d = 1'b1;
            state_d = S_HALT_ERR;
          end
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = S_HALT_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign prog       = prog_q;
  assign address    = address_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign reg_a      = ir_q[3:2];
  assign reg_b      = ir_q[1:0];
  assign lda_en     = lda_q;
  assign ldb_en     = ldb_q;
  assign push_en    = push_q;
  assign out_en     = out_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign step_count = step_q;

endmodule
